ofifo_aligned: RTL and testbench

- Parametrised output FIFO bank that collects PE-array column results for SRAM write-back.
- Holds COL independent circular buffers of depth DEPTH, written per column, each BW bits wide.
- Read side pops one aligned row from all columns at once, and only when every column holds data.
- Adds occupancy reporting, an almost-full watermark, a registered read port, and sticky overflow/underflow error flags.

---
 rtl/ofifo_aligned.sv | 89 ++++++++
 tb/tb_ofifo_aligned.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ofifo_aligned.sv
// ofifo_aligned: per-column circular FIFOs drained one aligned row at a time, with occupancy status and sticky error flags.
module ofifo_aligned #(
  parameter int COL = 8,
  parameter int BW = 16,
  parameter int DEPTH = 64,
  parameter int AF_LEVEL = 56,
  parameter int CW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [COL*BW-1:0] in,
  input  logic [COL-1:0]    wr,
  input  logic              rd,
  input  logic              clr_err,
  output logic [COL*BW-1:0] out,
  output logic              o_out_valid,
  output logic              o_valid,
  output logic              o_ready,
  output logic              o_full,
  output logic              o_almost_full,
  output logic [CW-1:0]     o_min_count,
  output logic              o_overflow,
  output logic              o_underflow
);
  localparam int AW = $clog2(DEPTH);
  logic [BW-1:0] mem_q [COL][DEPTH];
  logic [COL-1:0][AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [COL-1:0][CW-1:0] count_q, count_d;
  logic [COL*BW-1:0] out_q, out_d;
  logic out_valid_q, out_valid_d, overflow_q, overflow_d, underflow_q, underflow_d;
  logic [COL-1:0] wr_acc, nonempty, is_full;
  logic rd_acc;
  logic [CW-1:0] min_c, max_c;
  always_comb begin
    min_c = CW'(DEPTH);
    max_c = '0;
    for (int i = 0; i < COL; i++) begin
      nonempty[i] = count_q[i] != '0;
      is_full[i] = count_q[i] == CW'(DEPTH);
      min_c = count_q[i] < min_c ? count_q[i] : min_c;
      max_c = count_q[i] > max_c ? count_q[i] : max_c;
    end
    rd_acc = rd & (&nonempty);
    out_d = out_q;
    // a full column still takes a write when the same cycle pops a row
    for (int i = 0; i < COL; i++) begin
      wr_acc[i] = wr[i] & (~is_full[i] | rd_acc);
      wr_ptr_d[i] = wr_ptr_q[i] + AW'(wr_acc[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + AW'(rd_acc);
      count_d[i] = count_q[i] + CW'(wr_acc[i]) - CW'(rd_acc);
      out_d[i*BW +: BW] = rd_acc ? mem_q[i][rd_ptr_q[i]] : out_q[i*BW +: BW];
    end
    out_valid_d = rd_acc;
    overflow_d = (|(wr & ~wr_acc)) | (overflow_q & ~clr_err);
    underflow_d = (rd & ~rd_acc) | (underflow_q & ~clr_err);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      out_q <= '0;
      out_valid_q <= 1'b0;
      overflow_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      out_q <= out_d;
      out_valid_q <= out_valid_d;
      overflow_q <= overflow_d;
      underflow_q <= underflow_d;
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < COL; i++)
      if (!reset && wr_acc[i]) mem_q[i][wr_ptr_q[i]] <= in[i*BW +: BW];
  end
  assign out = out_q;
  assign o_out_valid = out_valid_q;
  assign o_valid = &nonempty;
  assign o_full = |is_full;
  assign o_ready = ~o_full;
  assign o_almost_full = max_c >= CW'(AF_LEVEL);
  assign o_min_count = min_c;
  assign o_overflow = overflow_q;
  assign o_underflow = underflow_q;
endmodule

// File: tb/tb_ofifo_aligned.sv
// tb_ofifo_aligned: scenario tasks checked against a queue-per-column reference model.
module tb_ofifo_aligned;
  logic clk = 0;
  logic reset = 1;
  logic [31:0] din = '0;
  logic [3:0] wr = '0;
  logic rd = 0, clr_err = 0;
  logic [31:0] dout;
  logic o_out_valid, o_valid, o_ready, o_full, o_almost_full, o_overflow, o_underflow;
  logic [3:0] o_min_count;
  logic [10:0] st;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] mq [4][$];
  logic [31:0] e_out = '0;
  logic e_ov = 0, e_ovf = 0, e_udf = 0;
  ofifo_aligned #(.COL(4), .BW(8), .DEPTH(8), .AF_LEVEL(6)) dut (
    .clk(clk), .reset(reset), .in(din), .wr(wr), .rd(rd), .clr_err(clr_err),
    .out(dout), .o_out_valid(o_out_valid), .o_valid(o_valid), .o_ready(o_ready),
    .o_full(o_full), .o_almost_full(o_almost_full), .o_min_count(o_min_count),
    .o_overflow(o_overflow), .o_underflow(o_underflow)
  );
  always #5 clk = ~clk;
  assign st = {o_valid, o_ready, o_full, o_almost_full, o_min_count, o_overflow, o_underflow, o_out_valid};
  function automatic logic [10:0] exp_stat();
    int mn = 8, mx = 0;
    logic v = 1, f = 0;
    for (int i = 0; i < 4; i++) begin
      int sz = mq[i].size();
      if (sz < mn) mn = sz;
      if (sz > mx) mx = sz;
      if (sz == 0) v = 0;
      if (sz == 8) f = 1;
    end
    return {v, ~f, f, mx >= 6, 4'(mn), e_ovf, e_udf, e_ov};
  endfunction
  task automatic drive(input logic [3:0] w, input logic [31:0] d, input logic r, input logic c, input logic rst);
    logic all, racc, nov;
    @(negedge clk);
    wr = w; din = d; rd = r; clr_err = c; reset = rst;
    if (rst) begin
      for (int i = 0; i < 4; i++) mq[i].delete();
      e_out = '0; e_ov = 0; e_ovf = 0; e_udf = 0;
    end else begin
      all = 1;
      for (int i = 0; i < 4; i++) if (mq[i].size() == 0) all = 0;
      racc = r & all;
      nov = 0;
      if (racc) for (int i = 0; i < 4; i++) e_out[i*8 +: 8] = mq[i].pop_front();
      for (int i = 0; i < 4; i++)
        if (w[i]) begin
          if (mq[i].size() < 8) mq[i].push_back(d[i*8 +: 8]);
          else nov = 1;
        end
      e_ov = racc;
      e_ovf = nov | (e_ovf & ~c);
      e_udf = (r & ~racc) | (e_udf & ~c);
    end
    @(posedge clk);
    #1;
    wr = '0; rd = 0; clr_err = 0; reset = 0;
  endtask
  task automatic test_reset();
    drive('0, '0, 0, 0, 1);
    drive('0, '0, 0, 0, 0);
    n_cmp++;
    if (st !== 11'b01_0_0_0000_000) begin n_bad++; $display("FAIL reset_stat: got %b want %b", st, 11'b01000000000); end
    n_cmp++;
    if (dout !== 32'h0) begin n_bad++; $display("FAIL reset_out: got %h want 0", dout); end
  endtask
  task automatic test_stagger();
    logic [31:0] rows [3] = '{32'h13121110, 32'h23222120, 32'h33323130};
    logic [31:0] d;
    int k = 0, guard = 0;
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 4; i++) begin
        d = $urandom;
        d[i*8 +: 8] = 8'(8'h10 * (r + 1) + i);
        drive(4'(1 << i), d, 0, 0, 0);
        n_cmp++;
        if (st !== exp_stat()) begin n_bad++; $display("FAIL stagger_wr_stat: got %b want %b", st, exp_stat()); end
      end
    while (o_valid && guard < 10) begin
      drive('0, '0, 1, 0, 0);
      guard++;
      n_cmp++;
      if (!o_out_valid || k > 2 || dout !== rows[k]) begin
        n_bad++; $display("FAIL stagger_row%0d: got %h valid %b want %h", k, dout, o_out_valid, rows[k % 3]);
      end
      k++;
    end
    n_cmp++;
    if (k != 3) begin n_bad++; $display("FAIL stagger_rows: got %0d want 3", k); end
    drive('0, '0, 0, 0, 0);
    n_cmp++;
    if (st !== exp_stat() || o_out_valid !== 1'b0) begin n_bad++; $display("FAIL stagger_idle: got %b want %b", st, exp_stat()); end
  endtask
  task automatic test_fill();
    logic [31:0] last = '0;
    for (int n = 0; n < 8; n++) begin
      drive(4'b0100, $urandom, 0, 0, 0);
      n_cmp++;
      if (st !== exp_stat()) begin n_bad++; $display("FAIL fill_stat%0d: got %b want %b", n, st, exp_stat()); end
    end
    n_cmp++;
    if ({o_full, o_ready, o_almost_full, o_min_count} !== 7'b1010000) begin
      n_bad++; $display("FAIL fill_full: got %b want 1010000", {o_full, o_ready, o_almost_full, o_min_count});
    end
    drive('0, '0, 1, 0, 0);
    n_cmp++;
    if (o_underflow !== 1'b1 || o_overflow !== 1'b0) begin n_bad++; $display("FAIL fill_udf: got %b%b want 01", o_overflow, o_underflow); end
    drive(4'b0100, $urandom, 0, 0, 0);
    n_cmp++;
    if (st !== exp_stat() || o_overflow !== 1'b1) begin n_bad++; $display("FAIL fill_ovf: got %b want %b", st, exp_stat()); end
    drive('0, '0, 0, 1, 0);
    n_cmp++;
    if (o_overflow !== 1'b0 || o_underflow !== 1'b0) begin n_bad++; $display("FAIL fill_clr: got %b%b want 00", o_overflow, o_underflow); end
    for (int n = 0; n < 8; n++) drive(4'b1011, $urandom, 0, 0, 0);
    n_cmp++;
    if (st !== exp_stat() || o_min_count !== 4'd8) begin n_bad++; $display("FAIL allfull_stat: got %b want %b", st, exp_stat()); end
    drive(4'b1111, 32'hAABBCCDD, 1, 0, 0);
    n_cmp++;
    if (st !== exp_stat() || o_min_count !== 4'd8 || o_overflow !== 1'b0) begin
      n_bad++; $display("FAIL full_rw_stat: got %b want %b", st, exp_stat());
    end
    n_cmp++;
    if (dout !== e_out) begin n_bad++; $display("FAIL full_rw_out: got %h want %h", dout, e_out); end
    for (int n = 0; n < 16; n++) begin
      drive('0, '0, 1, 0, 0);
      if (o_out_valid) last = dout;
      n_cmp++;
      if (st !== exp_stat() || dout !== e_out) begin n_bad++; $display("FAIL drain%0d: got %h/%b want %h/%b", n, dout, st, e_out, exp_stat()); end
    end
    n_cmp++;
    if (last !== 32'hAABBCCDD) begin n_bad++; $display("FAIL drain_last: got %h want aabbccdd", last); end
  endtask
  task automatic test_wrap();
    drive('0, '0, 0, 0, 1);
    for (int n = 0; n < 3; n++) drive(4'b1111, $urandom, 0, 0, 0);
    for (int n = 0; n < 20; n++) begin
      drive(4'b1111, $urandom, n[0], 0, 0);
      n_cmp++;
      if (st !== exp_stat() || dout !== e_out) begin n_bad++; $display("FAIL wrap%0d: got %h/%b want %h/%b", n, dout, st, e_out, exp_stat()); end
    end
    for (int n = 0; n < 10; n++) begin
      drive('0, '0, 1, 0, 0);
      n_cmp++;
      if (st !== exp_stat() || dout !== e_out) begin n_bad++; $display("FAIL wrap_drain%0d: got %h/%b want %h/%b", n, dout, st, e_out, exp_stat()); end
    end
  endtask
  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      drive(4'($urandom), $urandom, $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, 0);
      n_cmp++;
      if (st !== exp_stat() || dout !== e_out) begin n_bad++; $display("FAIL rand%0d: got %h/%b want %h/%b", n, dout, st, e_out, exp_stat()); end
    end
  endtask
  task automatic test_reset_mid();
    drive('0, '0, 0, 0, 1);
    for (int n = 0; n < 5; n++) drive(4'b1111, $urandom, 0, 0, 0);
    drive(4'b1111, $urandom, 1, 0, 1);
    n_cmp++;
    if (st !== 11'b01_0_0_0000_000 || st !== exp_stat()) begin n_bad++; $display("FAIL reset_mid_stat: got %b want 01000000000", st); end
    n_cmp++;
    if (dout !== 32'h0) begin n_bad++; $display("FAIL reset_mid_out: got %h want 0", dout); end
  endtask
  initial begin
    test_reset();
    test_stagger();
    test_fill();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
